// File: rtl/nfive32_rf_sb_if.sv
// Issue/read/writeback bundle between the NfiVe32 pipeline and its register file.
// The pipeline side is the master; the register file is the slave.
interface nfive32_rf_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            WR;
  logic [AW-1:0]   RW;
  logic [XLEN-1:0] DW;
  logic [AW-1:0]   RA;
  logic [AW-1:0]   RB;
  logic [XLEN-1:0] DA;
  logic [XLEN-1:0] DB;
  logic            BUSYA;
  logic            BUSYB;
  logic            ISSUE;
  logic [AW-1:0]   RD;
  logic            ISSUE_ACK;

  modport master (
    output WR, RW, DW, RA, RB, ISSUE, RD,
    input  DA, DB, BUSYA, BUSYB, ISSUE_ACK
  );

  modport slave (
    input  WR, RW, DW, RA, RB, ISSUE, RD,
    output DA, DB, BUSYA, BUSYB, ISSUE_ACK
  );
endinterface

// File: rtl/nfive32_rf_sb.sv
// NfiVe32 register file: two combinational read ports, one write port and a per-register
// pending-write scoreboard. Define NFIVE_RF_BYPASS_EN to forward the in-flight writeback.
module nfive32_rf_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  nfive32_rf_sb_if.slave     bus
);

  localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

  function automatic logic in_range(input logic [AW-1:0] idx);
    return ({1'b0, idx} < NREG_W);
  endfunction

  function automatic logic is_zero(input logic [AW-1:0] idx);
    return (ZERO_REG != 0) && (idx == '0);
  endfunction

  function automatic logic legal(input logic [AW-1:0] idx);
    return in_range(idx) && !is_zero(idx);
  endfunction

  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] pend;

  logic [XLEN-1:0] rf_a;
  logic [XLEN-1:0] rf_b;
  logic            pend_a;
  logic            pend_b;
  logic            pend_d;
  logic            wr_ok;
  logic            ack;
  logic            set_ok;

  // Index decode by loop so an out-of-range index simply matches nothing.
  always_comb begin
    rf_a   = '0;
    rf_b   = '0;
    pend_a = 1'b0;
    pend_b = 1'b0;
    pend_d = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (bus.RA == AW'(i)) begin
        rf_a   = rf[i];
        pend_a = pend[i];
      end
      if (bus.RB == AW'(i)) begin
        rf_b   = rf[i];
        pend_b = pend[i];
      end
      if (bus.RD == AW'(i)) begin
        pend_d = pend[i];
      end
    end
  end

  assign wr_ok  = bus.WR && legal(bus.RW);
  assign ack    = bus.ISSUE && in_range(bus.RD) && !pend_d;
  assign set_ok = ack && !is_zero(bus.RD);

  assign bus.ISSUE_ACK = ack;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
      pend <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_ok && (bus.RW == AW'(i))) begin
          rf[i] <= bus.DW;
        end
        // A new producer issued against the register being written back keeps it busy.
        if (set_ok && (bus.RD == AW'(i))) begin
          pend[i] <= 1'b1;
        end else if (wr_ok && (bus.RW == AW'(i))) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  logic [XLEN-1:0] reg_da;
  logic [XLEN-1:0] reg_db;
  logic            reg_busya;
  logic            reg_busyb;

  assign reg_da    = legal(bus.RA) ? rf_a : '0;
  assign reg_db    = legal(bus.RB) ? rf_b : '0;
  assign reg_busya = legal(bus.RA) && pend_a;
  assign reg_busyb = legal(bus.RB) && pend_b;

`ifdef NFIVE_RF_BYPASS_EN
  logic byp_a;
  logic byp_b;

  // wr_ok already excludes zero and out-of-range indices, so a match implies a legal read index.
  assign byp_a = wr_ok && (bus.RW == bus.RA);
  assign byp_b = wr_ok && (bus.RW == bus.RB);

  assign bus.DA    = byp_a ? bus.DW : reg_da;
  assign bus.DB    = byp_b ? bus.DW : reg_db;
  assign bus.BUSYA = reg_busya && !byp_a;
  assign bus.BUSYB = reg_busyb && !byp_b;
`else
  assign bus.DA    = reg_da;
  assign bus.DB    = reg_db;
  assign bus.BUSYA = reg_busya;
  assign bus.BUSYB = reg_busyb;
`endif

endmodule
